mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one unified memory port between the processor's instruction-fetch requester (I) and its load/store requester (D).
//   Sits between PC/ProgramMemory fetch logic, the data-access path and a single external memory with variable latency.
//   Fixed D-over-I priority, with a starvation guard for I and a per-transaction timeout that returns an error.
// PARAMETERS
//   ADDR_WIDTH      32  address width of all ports
//   DATA_WIDTH      32  data width of all ports
//   MAX_D_STREAK    4   consecutive D grants allowed while I is waiting (>=1)
//   TIMEOUT_CYCLES  16  BUSY cycles without mem_ready before error (>=2)
// PORTS
//   clk        in   1           rising-edge clock
//   reset      in   1           asynchronous, active-low reset
//   i_req      in   1           fetch request; held with i_addr stable until i_ready
//   i_addr     in   ADDR_WIDTH  fetch address
//   i_ready    out  1           1-cycle completion pulse for I
//   i_rdata    out  DATA_WIDTH  fetched word; valid while i_ready=1
//   i_err      out  1           I transaction timed out; valid while i_ready=1
//   d_req      in   1           data request; held with d_we/d_addr/d_wdata stable until d_ready
//   d_we       in   1           1=store, 0=load
//   d_addr     in   ADDR_WIDTH  data address
//   d_wdata    in   DATA_WIDTH  store data
//   d_ready    out  1           1-cycle completion pulse for D
//   d_rdata    out  DATA_WIDTH  load data; valid while d_ready=1; 0 for stores
//   d_err      out  1           D transaction timed out; valid while d_ready=1
//   mem_req    out  1           memory request; held until mem_ready or timeout
//   mem_we     out  1           memory write enable
//   mem_addr   out  ADDR_WIDTH  memory address (registered)
//   mem_wdata  out  DATA_WIDTH  memory write data (registered)
//   mem_rdata  in   DATA_WIDTH  memory read data; valid with mem_ready
//   mem_ready  in   1           memory completion, sampled only while mem_req=1
//   busy       out  1           1 whenever state != IDLE
// BEHAVIOUR
//   - Reset (reset=0): state=IDLE; streak=0; timeout counter=0; every output=0, mem_req included, effective immediately.
//   - FSM states: IDLE -> BUSY_I | BUSY_D -> RESP -> IDLE.
//   - IDLE: grant is decided from req levels at the clock edge.
//       Only D requesting -> D; only I -> I.
//       Both requesting -> D unless streak==MAX_D_STREAK, in which case I.
//       Selected requester's fields are registered onto mem_*; next state is BUSY_x with mem_req=1.
//   - Streak: +1 on a D grant while i_req=1; cleared on any I grant and on a D grant while i_req=0.
//   - BUSY_x: mem_req=1 and mem_* held constant; timeout counter +1 per cycle.
//       mem_ready=1 -> capture mem_rdata (0 for a store) and go to RESP with err=0.
//       Counter reaching TIMEOUT_CYCLES without mem_ready -> go to RESP with err=1 and rdata=0.
//       mem_ready and timeout in the same cycle: mem_ready wins, err=0.
//   - RESP: mem_req=0; the owner's x_ready=1 for exactly one cycle with x_rdata/x_err valid; then IDLE.
//       Requests are ignored in RESP; a requester may keep req high in its ready cycle.
//   - The non-owner's ready, rdata and err stay 0 throughout.
//   - Latency: req seen in IDLE at cycle 0, mem_req at cycle 1, earliest x_ready at cycle 2.
//       Minimum 3 cycles per transaction; no back-to-back overlap.
//   - Requester dropping req mid-transaction is illegal; the transaction still completes and ready still pulses.
//   - Reset mid-transaction aborts it: no ready pulse; the requester must reissue.
// TESTING
//   1. I only, addr 0x00400004, mem_ready 1 cycle after mem_req, mem_rdata=0x2008000A -> i_ready at cycle 2, i_rdata=0x2008000A, i_err=0, d_ready never 1.
//   2. D store, addr 0x10010000, wdata 0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF held until mem_ready; d_ready pulse, d_rdata=0.
//   3. i_req and d_req held high continuously, mem_ready immediate -> grant order D,D,D,D,I,D,D,D,D,I.
//   4. D load, mem_ready never asserted -> mem_req high for 16 cycles then 0; d_ready=1, d_err=1, d_rdata=0.
//   5. mem_ready asserted in the 16th BUSY cycle -> d_err=0 and d_rdata=mem_rdata.
//   6. reset pulled low during BUSY_D -> mem_req=0 and all outputs 0 asynchronously; after release, IDLE and a new I request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - I/D requester and shared memory signals of mem_port_arbiter
// slave is the arbiter's view; master is the view of the requesters plus the memory.
`timescale 1ns/1ps
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  i_err;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_ready;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_err;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;

    modport slave (
        input  i_req, i_addr,
        output i_ready, i_rdata, i_err,
        input  d_req, d_we, d_addr, d_wdata,
        output d_ready, d_rdata, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output i_req, i_addr,
        input  i_ready, i_rdata, i_err,
        output d_req, d_we, d_addr, d_wdata,
        input  d_ready, d_rdata, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch (I) and load/store (D)
// D-over-I priority with an I starvation guard and a per-transaction timeout.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_D_STREAK   = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus,
    output logic               busy
);
    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam int TO_W     = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arbState;

    arbState               state;
    arbState               nextState;
    logic [STREAK_W-1:0]   streak;
    logic [TO_W-1:0]       toCount;
    logic                  ownerD;
    logic                  memReqQ;
    logic                  memWeQ;
    logic [ADDR_WIDTH-1:0] memAddrQ;
    logic [DATA_WIDTH-1:0] memWdataQ;
    logic [DATA_WIDTH-1:0] respData;
    logic                  respErr;
    logic                  grantD;
    logic                  grantI;
    logic                  inBusy;
    logic                  timeoutHit;
    logic                  respValid;

    // I wins a tie only once D has used up its streak allowance.
    always_comb begin
        grantD = 1'b0;
        grantI = 1'b0;
        if (bus.d_req && !(bus.i_req && (streak == STREAK_W'(MAX_D_STREAK)))) begin
            grantD = 1'b1;
        end else if (bus.i_req) begin
            grantI = 1'b1;
        end
    end

    assign inBusy     = (state == BUSY_I) || (state == BUSY_D);
    assign timeoutHit = (toCount == TO_W'(TIMEOUT_CYCLES - 1));
    assign respValid  = (state == RESP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (grantD) begin
                    nextState = BUSY_D;
                end else if (grantI) begin
                    nextState = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_ready || timeoutHit) begin
                    nextState = RESP;
                end
            end
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak    <= '0;
            toCount   <= '0;
            ownerD    <= 1'b0;
            memReqQ   <= 1'b0;
            memWeQ    <= 1'b0;
            memAddrQ  <= '0;
            memWdataQ <= '0;
            respData  <= '0;
            respErr   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    toCount <= '0;
                    if (grantD) begin
                        ownerD    <= 1'b1;
                        memReqQ   <= 1'b1;
                        memWeQ    <= bus.d_we;
                        memAddrQ  <= bus.d_addr;
                        memWdataQ <= bus.d_wdata;
                        streak    <= bus.i_req ? streak + 1'b1 : '0;
                    end else if (grantI) begin
                        ownerD    <= 1'b0;
                        memReqQ   <= 1'b1;
                        memWeQ    <= 1'b0;
                        memAddrQ  <= bus.i_addr;
                        memWdataQ <= '0;
                        streak    <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // A completion arriving on the timeout cycle still counts as success.
                    if (bus.mem_ready) begin
                        memReqQ  <= 1'b0;
                        toCount  <= '0;
                        respData <= memWeQ ? '0 : bus.mem_rdata;
                        respErr  <= 1'b0;
                    end else if (timeoutHit) begin
                        memReqQ  <= 1'b0;
                        toCount  <= '0;
                        respData <= '0;
                        respErr  <= 1'b1;
                    end else begin
                        toCount <= toCount + 1'b1;
                    end
                end
                RESP: begin
                    respData <= '0;
                    respErr  <= 1'b0;
                end
                default: begin
                    memReqQ <= 1'b0;
                    toCount <= '0;
                end
            endcase
        end
    end

    assign bus.mem_req   = memReqQ;
    assign bus.mem_we    = memWeQ;
    assign bus.mem_addr  = memAddrQ;
    assign bus.mem_wdata = memWdataQ;

    // Response fields are gated so the non-owner always reads zero.
    assign bus.i_ready = respValid && !ownerD;
    assign bus.i_rdata = bus.i_ready ? respData : '0;
    assign bus.i_err   = bus.i_ready && respErr;
    assign bus.d_ready = respValid && ownerD;
    assign bus.d_rdata = bus.d_ready ? respData : '0;
    assign bus.d_err   = bus.d_ready && respErr;

    assign busy = (state != IDLE) || inBusy;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;
    localparam int TOC  = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    mem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_D_STREAK(MAXS), .TIMEOUT_CYCLES(TOC)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.slave), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Memory behaviour: answers memLatency cycles after mem_req rises, or never.
    int        memLatency = 0;
    bit        memNever = 1'b0;
    bit        memFixed = 1'b0;
    logic [31:0] memFixedData = 32'h0;
    int        memCnt = 0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    always @(negedge clk) begin
        if (bus.mem_req) begin
            bus.mem_ready = !memNever && (memCnt == memLatency);
            bus.mem_rdata = memNever ? $urandom : (memFixed ? memFixedData : memWord(bus.mem_addr));
            memCnt++;
        end else begin
            bus.mem_ready = 1'b0;
            bus.mem_rdata = $urandom;
            memCnt = 0;
        end
    end

    // Reference arbitration: D wins ties until it has won MAXS in a row with I waiting.
    int modelStreak = 0;
    function automatic bit modelPickD(input bit iR, input bit dR);
        bit d;
        d = dR && !(iR && modelStreak == MAXS);
        if (d && iR) modelStreak++;
        else modelStreak = 0;
        return d;
    endfunction

    int          obsEdges, obsReqCycles;
    bit          obsDone, obsTimeout, obsI, obsD, obsMemSeen, obsHoldBad, obsErr;
    logic [31:0] obsRdata, obsAddr, obsWdata;
    logic        obsWe;
    logic [32:0] obsOther;

    task automatic waitTxn();
        obsEdges = 0; obsReqCycles = 0; obsDone = 0; obsTimeout = 0;
        obsI = 0; obsD = 0; obsMemSeen = 0; obsHoldBad = 0; obsErr = 0;
        obsRdata = '0; obsAddr = '0; obsWdata = '0; obsWe = 0; obsOther = '0;
        while (!obsDone && obsEdges < 60) begin
            @(posedge clk);
            obsEdges++;
            @(negedge clk);
            if (bus.mem_req) begin
                obsReqCycles++;
                if (!obsMemSeen) begin
                    obsMemSeen = 1;
                    obsAddr = bus.mem_addr; obsWe = bus.mem_we; obsWdata = bus.mem_wdata;
                end else if (bus.mem_addr !== obsAddr || bus.mem_we !== obsWe || bus.mem_wdata !== obsWdata) begin
                    obsHoldBad = 1;
                end
            end
            if (bus.i_ready || bus.d_ready) begin
                obsDone = 1;
                obsI = bus.i_ready; obsD = bus.d_ready;
                obsRdata = bus.i_ready ? bus.i_rdata : bus.d_rdata;
                obsErr   = bus.i_ready ? bus.i_err : bus.d_err;
                obsOther = bus.i_ready ? {bus.d_rdata, bus.d_err} : {bus.i_rdata, bus.i_err};
            end
        end
        if (!obsDone) obsTimeout = 1;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        modelStreak = 0;
    endtask

    task automatic test_reset();
        bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, bus.mem_req, bus.mem_we, bus.i_ready, bus.i_err, bus.d_ready, bus.d_err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0", {busy, bus.mem_req, bus.mem_we, bus.i_ready, bus.i_err, bus.d_ready, bus.d_err});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata} !== 128'b0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata});
        end
        reset = 1'b1;
        modelStreak = 0;
        @(negedge clk);
    endtask

    task automatic test_i_only();
        memFixed = 1; memFixedData = 32'h2008000A; memLatency = 0; memNever = 0;
        bus.i_addr = 32'h00400004; bus.i_req = 1;
        void'(modelPickD(1'b1, 1'b0));
        waitTxn();
        bus.i_req = 0;
        checks++;
        if (obsTimeout || {obsI, obsD} !== 2'b10) begin
            failures++; $display("FAIL i_only_owner got=%b%b exp=10", obsI, obsD);
        end
        checks++;
        if (obsEdges !== 2) begin failures++; $display("FAIL i_only_latency got=%0d exp=2", obsEdges); end
        checks++;
        if (obsRdata !== 32'h2008000A || obsErr !== 1'b0) begin
            failures++; $display("FAIL i_only_data got=%h/%b exp=2008000a/0", obsRdata, obsErr);
        end
        checks++;
        if (obsAddr !== 32'h00400004 || obsWe !== 1'b0) begin
            failures++; $display("FAIL i_only_memaddr got=%h/%b exp=00400004/0", obsAddr, obsWe);
        end
        @(negedge clk);
        checks++;
        if ({bus.i_ready, bus.d_ready, busy} !== 3'b000) begin
            failures++; $display("FAIL i_only_pulse got=%b exp=000", {bus.i_ready, bus.d_ready, busy});
        end
        memFixed = 0;
    endtask

    task automatic test_d_store();
        memLatency = 2; memNever = 0;
        bus.d_we = 1; bus.d_addr = 32'h10010000; bus.d_wdata = 32'hDEADBEEF; bus.d_req = 1;
        void'(modelPickD(1'b0, 1'b1));
        waitTxn();
        bus.d_req = 0;
        checks++;
        if (obsTimeout || {obsI, obsD} !== 2'b01) begin
            failures++; $display("FAIL d_store_owner got=%b%b exp=01", obsI, obsD);
        end
        checks++;
        if (obsWe !== 1'b1 || obsWdata !== 32'hDEADBEEF || obsAddr !== 32'h10010000 || obsHoldBad) begin
            failures++; $display("FAIL d_store_mem got=%b/%h/%h hold_bad=%0d exp=1/deadbeef/10010000", obsWe, obsWdata, obsAddr, obsHoldBad);
        end
        checks++;
        if (obsReqCycles !== 3 || obsEdges !== 4) begin
            failures++; $display("FAIL d_store_cycles got=%0d/%0d exp=3/4", obsReqCycles, obsEdges);
        end
        checks++;
        if (obsRdata !== 32'h0 || obsErr !== 1'b0) begin
            failures++; $display("FAIL d_store_resp got=%h/%b exp=0/0", obsRdata, obsErr);
        end
        memLatency = 0;
        @(negedge clk);
    endtask

    task automatic test_priority();
        logic [9:0] order;
        bit         expD;
        memLatency = 0; memNever = 0;
        pulseReset();
        bus.i_addr = 32'h00400100; bus.d_we = 0; bus.d_addr = 32'h10010040; bus.d_wdata = '0;
        bus.i_req = 1; bus.d_req = 1;
        order = '0;
        for (int k = 0; k < 10; k++) begin
            expD = modelPickD(1'b1, 1'b1);
            waitTxn();
            order[k] = obsD;
            checks++;
            if (obsTimeout || obsD !== expD || obsI !== !expD) begin
                failures++; $display("FAIL prio_grant k=%0d got=%b%b exp_d=%0d", k, obsI, obsD, expD);
            end
            checks++;
            if (obsEdges !== ((k == 0) ? 2 : 3)) begin
                failures++; $display("FAIL prio_spacing k=%0d got=%0d exp=%0d", k, obsEdges, (k == 0) ? 2 : 3);
            end
        end
        bus.i_req = 0; bus.d_req = 0;
        checks++;
        if (order !== 10'b0111101111) begin
            failures++; $display("FAIL prio_order got=%b exp=0111101111", order);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        memNever = 1;
        bus.d_we = 0; bus.d_addr = 32'h10010080; bus.d_req = 1;
        void'(modelPickD(1'b0, 1'b1));
        waitTxn();
        bus.d_req = 0;
        checks++;
        if (obsTimeout || obsReqCycles !== TOC || obsEdges !== TOC + 1) begin
            failures++; $display("FAIL timeout_cycles got=%0d/%0d exp=%0d/%0d", obsReqCycles, obsEdges, TOC, TOC + 1);
        end
        checks++;
        if (obsD !== 1'b1 || obsErr !== 1'b1 || obsRdata !== 32'h0) begin
            failures++; $display("FAIL timeout_resp got=%b/%b/%h exp=1/1/0", obsD, obsErr, obsRdata);
        end
        checks++;
        if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL timeout_memreq got=%b exp=0", bus.mem_req); end
        memNever = 0;
        @(negedge clk);
    endtask

    task automatic test_late_ready();
        memLatency = TOC - 1; memNever = 0;
        bus.d_we = 0; bus.d_addr = 32'h100100C4; bus.d_req = 1;
        void'(modelPickD(1'b0, 1'b1));
        waitTxn();
        bus.d_req = 0;
        checks++;
        if (obsTimeout || obsReqCycles !== TOC) begin
            failures++; $display("FAIL late_cycles got=%0d exp=%0d", obsReqCycles, TOC);
        end
        checks++;
        if (obsD !== 1'b1 || obsErr !== 1'b0 || obsRdata !== memWord(32'h100100C4)) begin
            failures++; $display("FAIL late_resp got=%b/%b/%h exp=1/0/%h", obsD, obsErr, obsRdata, memWord(32'h100100C4));
        end
        memLatency = 0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        memNever = 1;
        bus.d_we = 0; bus.d_addr = 32'h10010100; bus.d_req = 1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({bus.mem_req, busy, bus.d_ready, bus.d_err, bus.i_ready} !== 5'b0 || bus.mem_addr !== 32'h0) begin
            failures++; $display("FAIL async_reset got=%b addr=%h exp=0", {bus.mem_req, busy, bus.d_ready, bus.d_err, bus.i_ready}, bus.mem_addr);
        end
        bus.d_req = 0;
        @(negedge clk);
        reset = 1'b1;
        modelStreak = 0;
        memNever = 0; memLatency = 0;
        @(negedge clk);
        checks++;
        if ({busy, bus.d_ready, bus.mem_req} !== 3'b000) begin
            failures++; $display("FAIL post_reset_idle got=%b exp=000", {busy, bus.d_ready, bus.mem_req});
        end
        bus.i_addr = 32'h00400040; bus.i_req = 1;
        void'(modelPickD(1'b1, 1'b0));
        waitTxn();
        bus.i_req = 0;
        checks++;
        if (obsTimeout || obsI !== 1'b1 || obsEdges !== 2 || obsErr !== 1'b0 || obsRdata !== memWord(32'h00400040)) begin
            failures++; $display("FAIL post_reset_txn got=%b/%0d/%b/%h exp=1/2/0/%h", obsI, obsEdges, obsErr, obsRdata, memWord(32'h00400040));
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        bit          iPend, dPend, dWe, expD;
        logic [31:0] iA, dA, dW, expAddr, expRdata;
        iPend = 0; dPend = 0; dWe = 0; iA = '0; dA = '0; dW = '0;
        for (int n = 0; n < 40; n++) begin
            if (!iPend && $urandom_range(0, 2) != 0) begin
                iPend = 1; iA = $urandom; bus.i_addr = iA; bus.i_req = 1;
            end
            if (!dPend && ($urandom_range(0, 2) != 0 || !iPend)) begin
                dPend = 1; dA = $urandom; dW = $urandom; dWe = 1'($urandom_range(0, 1));
                bus.d_addr = dA; bus.d_wdata = dW; bus.d_we = dWe; bus.d_req = 1;
            end
            memNever = ($urandom_range(0, 9) == 0);
            memLatency = $urandom_range(0, 3);
            expD = modelPickD(iPend, dPend);
            expAddr = expD ? dA : iA;
            expRdata = (memNever || (expD && dWe)) ? 32'h0 : memWord(expAddr);
            waitTxn();
            checks++;
            if (obsTimeout || {obsI, obsD} !== {!expD, expD}) begin
                failures++; $display("FAIL rnd_grant n=%0d got=%b%b exp_d=%0d", n, obsI, obsD, expD);
            end
            checks++;
            if (obsAddr !== expAddr || obsWe !== (expD && dWe) || (expD && dWe && obsWdata !== dW) || obsHoldBad) begin
                failures++; $display("FAIL rnd_mem n=%0d got=%h/%b/%h hold_bad=%0d exp=%h/%b/%h", n, obsAddr, obsWe, obsWdata, obsHoldBad, expAddr, expD && dWe, dW);
            end
            checks++;
            if (obsRdata !== expRdata || obsErr !== memNever) begin
                failures++; $display("FAIL rnd_resp n=%0d got=%h/%b exp=%h/%b", n, obsRdata, obsErr, expRdata, memNever);
            end
            checks++;
            if (obsReqCycles !== (memNever ? TOC : memLatency + 1) || obsOther !== 33'b0) begin
                failures++; $display("FAIL rnd_cycles n=%0d got=%0d other=%h exp=%0d", n, obsReqCycles, obsOther, memNever ? TOC : memLatency + 1);
            end
            if (expD) begin dPend = 0; bus.d_req = 0; end
            else begin iPend = 0; bus.i_req = 0; end
        end
        bus.i_req = 0; bus.d_req = 0;
        memNever = 0; memLatency = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_i_only();
        test_d_store();
        test_priority();
        test_timeout();
        test_late_ready();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
